// File: rtl/dfr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dfr_sequencer
// Description : Run-control sequencer that steps the reservoir through the
//               INIT, TRAIN and TEST phases over a valid/ready handshake and
//               generates the input-sample word address for every step.
//               Optional stall counter output: define DFR_SEQ_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dfr_sequencer #(
    parameter int ADDR_W = 30,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_init_samples,
    input  logic [CNT_W-1:0]  num_init_steps,
    input  logic [CNT_W-1:0]  num_train_samples,
    input  logic [CNT_W-1:0]  num_train_steps,
    input  logic [CNT_W-1:0]  num_test_samples,
    input  logic [CNT_W-1:0]  num_test_steps,
    input  logic [CNT_W-1:0]  num_steps_per_sample,
    input  logic              step_ready,
    output logic              step_valid,
    output logic [1:0]        phase,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              sample_first,
    output logic              sample_last,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef DFR_SEQ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_init  = 3'd1;
    localparam logic [2:0] c_st_train = 3'd2;
    localparam logic [2:0] c_st_test  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_init_steps, r_train_steps, r_test_steps;
    logic [CNT_W-1:0]  r_init_samps, r_train_samps, r_test_samps;
    logic [CNT_W-1:0]  r_base_train, r_base_test;
    logic [CNT_W-1:0]  r_spp;
    logic [CNT_W-1:0]  r_step_cnt, r_samp_cnt, r_sub_cnt;
    logic              r_step_valid, r_busy, r_done, r_err, r_first, r_last;
    logic [1:0]        r_phase;
    logic [ADDR_W-1:0] r_addr;

    logic [CNT_W-1:0]  w_cur_steps, w_cur_samps, w_cur_base, w_nxt_base;
    logic [2:0]        w_nxt_state;
    logic              w_in_phase, w_accept, w_sub_wrap, w_last_step, w_adv;
    logic [CNT_W-1:0]  w_sub_next, w_samp_next, w_addr_next, w_final_samps;

    always_comb begin
        w_cur_steps = r_init_steps;
        w_cur_samps = r_init_samps;
        w_cur_base  = '0;
        w_nxt_state = c_st_train;
        w_nxt_base  = r_base_train;
        case (r_state)
            c_st_train: begin
                w_cur_steps = r_train_steps;
                w_cur_samps = r_train_samps;
                w_cur_base  = r_base_train;
                w_nxt_state = c_st_test;
                w_nxt_base  = r_base_test;
            end
            c_st_test: begin
                w_cur_steps = r_test_steps;
                w_cur_samps = r_test_samps;
                w_cur_base  = r_base_test;
                w_nxt_state = c_st_done;
                w_nxt_base  = '0;
            end
            default: ;
        endcase
    end

    assign w_in_phase    = (r_state == c_st_init) || (r_state == c_st_train) ||
                           (r_state == c_st_test);
    assign w_accept      = r_step_valid & step_ready;
    assign w_sub_wrap    = (r_sub_cnt == r_spp - c_one);
    assign w_sub_next    = w_sub_wrap ? '0 : r_sub_cnt + c_one;
    assign w_samp_next   = w_sub_wrap ? r_samp_cnt + c_one : r_samp_cnt;
    assign w_addr_next   = w_cur_base + w_samp_next;
    assign w_last_step   = (r_step_cnt == w_cur_steps - c_one);
    // The final step always closes a sample, whole or partial.
    assign w_final_samps = r_samp_cnt + c_one;
    assign w_adv         = w_in_phase &&
                           ((!r_step_valid && (w_cur_steps == '0)) ||
                            (w_accept && w_last_step));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_init_steps  <= '0;
            r_train_steps <= '0;
            r_test_steps  <= '0;
            r_init_samps  <= '0;
            r_train_samps <= '0;
            r_test_samps  <= '0;
            r_base_train  <= '0;
            r_base_test   <= '0;
            r_spp         <= '0;
            r_step_cnt    <= '0;
            r_samp_cnt    <= '0;
            r_sub_cnt     <= '0;
            r_step_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_first       <= 1'b0;
            r_last        <= 1'b0;
            r_phase       <= 2'd0;
            r_addr        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_init_steps  <= num_init_steps;
                        r_train_steps <= num_train_steps;
                        r_test_steps  <= num_test_steps;
                        r_init_samps  <= num_init_samples;
                        r_train_samps <= num_train_samples;
                        r_test_samps  <= num_test_samples;
                        r_base_train  <= num_init_samples;
                        r_base_test   <= num_init_samples + num_train_samples;
                        r_spp         <= (num_steps_per_sample == '0) ? c_one
                                                                      : num_steps_per_sample;
                        r_err         <= 1'b0;
                        r_state       <= c_st_init;
                        r_busy        <= 1'b1;
                        r_phase       <= 2'd1;
                        r_step_valid  <= 1'b0;
                        r_step_cnt    <= '0;
                        r_samp_cnt    <= '0;
                        r_sub_cnt     <= '0;
                        r_first       <= 1'b0;
                        r_last        <= 1'b0;
                        r_addr        <= '0;
                    end
                end
                c_st_init, c_st_train, c_st_test: begin
                    if (w_adv) begin
                        if (r_step_valid && (w_final_samps != w_cur_samps)) begin
                            r_err <= 1'b1;
                        end
                        r_state      <= w_nxt_state;
                        r_phase      <= w_nxt_state[1:0];
                        r_done       <= (w_nxt_state == c_st_done);
                        r_step_valid <= 1'b0;
                        r_step_cnt   <= '0;
                        r_samp_cnt   <= '0;
                        r_sub_cnt    <= '0;
                        r_first      <= 1'b0;
                        r_last       <= 1'b0;
                        r_addr       <= w_nxt_base[ADDR_W-1:0];
                    end else if (!r_step_valid) begin
                        // Reload bubble over; the first step opens sample 0.
                        r_step_valid <= 1'b1;
                        r_first      <= 1'b1;
                        r_last       <= (r_spp == c_one);
                    end else if (w_accept) begin
                        r_step_cnt <= r_step_cnt + c_one;
                        r_sub_cnt  <= w_sub_next;
                        r_samp_cnt <= w_samp_next;
                        r_addr     <= w_addr_next[ADDR_W-1:0];
                        r_first    <= (w_sub_next == '0);
                        r_last     <= (w_sub_next == r_spp - c_one);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                    r_phase <= 2'd0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef DFR_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || ((r_state == c_st_idle) && start)) begin
            r_stall_cnt <= '0;
        end else if (r_step_valid && !step_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_one;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

    assign step_valid   = r_step_valid;
    assign phase        = r_phase;
    assign sample_addr  = r_addr;
    assign sample_first = r_first;
    assign sample_last  = r_last;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dfr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfr_sequencer
// Description : Self-checking bench for dfr_sequencer against a cycle-level
//               reference model built from step index arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfr_sequencer;

    localparam int ADDR_W = 30;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_init_samples = '0, num_init_steps = '0;
    logic [CNT_W-1:0]  num_train_samples = '0, num_train_steps = '0;
    logic [CNT_W-1:0]  num_test_samples = '0, num_test_steps = '0;
    logic [CNT_W-1:0]  num_steps_per_sample = '0;
    logic              step_ready = 1'b1;
    logic              step_valid;
    logic [1:0]        phase;
    logic [ADDR_W-1:0] sample_addr;
    logic              sample_first, sample_last, busy, done, err;
`ifdef DFR_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cycles;
`endif

    dfr_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_init_samples     (num_init_samples),
        .num_init_steps       (num_init_steps),
        .num_train_samples    (num_train_samples),
        .num_train_steps      (num_train_steps),
        .num_test_samples     (num_test_samples),
        .num_test_steps       (num_test_steps),
        .num_steps_per_sample (num_steps_per_sample),
        .step_ready           (step_ready),
        .step_valid           (step_valid),
        .phase                (phase),
        .sample_addr          (sample_addr),
        .sample_first         (sample_first),
        .sample_last          (sample_last),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
`ifdef DFR_SEQ_STALL_CNT_EN
        ,
        .stall_cycles         (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: m_st 0=idle 1..3=phase 4=done; m_k = steps done in phase.
    int unsigned       m_st = 0;
    bit                m_bub = 1'b1;
    int unsigned       m_k = 0;
    bit                m_err = 1'b0;
    logic [CNT_W-1:0]  m_steps [1:3];
    logic [CNT_W-1:0]  m_samps [1:3];
    logic [CNT_W-1:0]  m_base  [1:3];
    int unsigned       m_spp = 1;
    logic [CNT_W-1:0]  m_stall = '0;

    logic [ADDR_W-1:0] q_addr [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_counts(input logic [31:0] is, input logic [31:0] it,
                              input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] ts, input logic [31:0] tt,
                              input logic [31:0] spp);
        num_init_samples  = is;  num_init_steps  = it;
        num_train_samples = rs;  num_train_steps = rt;
        num_test_samples  = ts;  num_test_steps  = tt;
        num_steps_per_sample = spp;
    endtask

    task automatic model_step(input bit rs, input bit st, input bit rdy);
        longint unsigned nsamp;
        if (rs) begin
            m_st = 0; m_bub = 1; m_k = 0; m_err = 0; m_spp = 1; m_stall = '0;
        end else if (m_st == 0) begin
            if (st) begin
                m_steps[1] = num_init_steps;  m_samps[1] = num_init_samples;
                m_steps[2] = num_train_steps; m_samps[2] = num_train_samples;
                m_steps[3] = num_test_steps;  m_samps[3] = num_test_samples;
                m_base[1]  = '0;
                m_base[2]  = num_init_samples;
                m_base[3]  = num_init_samples + num_train_samples;
                m_spp      = (num_steps_per_sample == 0) ? 1 : num_steps_per_sample;
                m_err = 0; m_stall = '0;
                m_st = 1; m_bub = 1; m_k = 0;
            end
        end else if (m_st == 4) begin
            m_st = 0;
        end else if (m_bub) begin
            if (m_steps[m_st] == 0) m_st++;
            else m_bub = 0;
        end else if (rdy) begin
            if (m_k == m_steps[m_st] - 1) begin
                nsamp = (longint'(m_steps[m_st]) + m_spp - 1) / m_spp;
                if (nsamp != longint'(m_samps[m_st])) m_err = 1;
                m_st++; m_bub = 1; m_k = 0;
            end else begin
                m_k++;
            end
        end else if (m_stall != '1) begin
            m_stall = m_stall + 1;
        end
    endtask

    task automatic check_outputs();
        bit in_ph;
        bit ev;
        logic [CNT_W-1:0] a;
        in_ph = (m_st >= 1) && (m_st <= 3);
        ev    = in_ph && !m_bub;
        check_eq("busy", busy, m_st != 0);
        check_eq("done", done, m_st == 4);
        if (m_st != 4) check_eq("phase", phase, in_ph ? m_st : 0);
        check_eq("step_valid", step_valid, ev);
        check_eq("err", err, m_err);
        check_eq("sample_first", sample_first, ev && (m_k % m_spp == 0));
        check_eq("sample_last", sample_last, ev && (m_k % m_spp == m_spp - 1));
        if (in_ph) begin
            a = m_base[m_st] + CNT_W'(m_k / m_spp);
            check_eq("sample_addr", sample_addr, a[ADDR_W-1:0]);
        end
`ifdef DFR_SEQ_STALL_CNT_EN
        check_eq("stall_cycles", stall_cycles, m_stall);
`endif
    endtask

    task automatic cycle(input bit rs, input bit st, input bit rdy);
        rst = rs; start = st; step_ready = rdy;
        if (step_valid && rdy && !rs) q_addr.push_back(sample_addr);
        @(posedge clk);
        model_step(rs, st, rdy);
        #1;
        check_outputs();
    endtask

    // mode 0: ready always high, 1: toggling, 2: random (with stray starts)
    task automatic run(input int mode);
        int n;
        bit t;
        bit rdy;
        n = 0; t = 1'b1;
        q_addr.delete();
        cycle(0, 1, 1);
        while (m_st != 0 && n < 500) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? t : 1'($urandom_range(0, 1));
            t = ~t;
            if (mode == 2 && $urandom_range(0, 15) == 0) begin
                set_counts($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
                cycle(0, 1, rdy);
            end else begin
                cycle(0, 0, rdy);
            end
            n++;
        end
        check_eq("run_end_busy", busy, 0);
    endtask

    task automatic check_addr_seq(input string tag, input logic [ADDR_W-1:0] exp [$]);
        check_eq({tag, "_len"}, q_addr.size(), exp.size());
        for (int i = 0; i < exp.size() && i < q_addr.size(); i++)
            check_eq(tag, q_addr[i], exp[i]);
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_a [$];
        int n;
        logic [31:0] spp, s_i, s_r, s_t, t_i, t_r, t_t;

        // Reset held with start asserted: start must be ignored.
        for (int i = 0; i < 3; i++) cycle(1, 1, 1);
        check_eq("rst_addr", sample_addr, 0);
        cycle(0, 0, 1);

        // Nominal run, ready always high.
        set_counts(2, 4, 3, 6, 1, 2, 2);
        run(0);
        exp_a = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        check_addr_seq("addr_seq_ready", exp_a);
        check_eq("nominal_err", err, 0);

        // Same counts with ready toggling every cycle.
        run(1);
        check_addr_seq("addr_seq_toggle", exp_a);

        // Empty INIT/TEST, spp=0 treated as 1, sample-count mismatch in TRAIN.
        set_counts(0, 0, 1, 3, 0, 0, 0);
        run(0);
        exp_a = '{0, 1, 2};
        check_addr_seq("addr_seq_spp0", exp_a);
        check_eq("spp0_err", err, 1);

        // Restart ignored mid-run, then reset mid-TRAIN.
        set_counts(2, 4, 3, 6, 1, 2, 2);
        cycle(0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        set_counts(9, 9, 9, 9, 9, 9, 5);
        cycle(0, 1, 1);
        n = 0;
        while (!(m_st == 2 && !m_bub && m_k >= 1) && n < 50) begin
            cycle(0, 0, 1);
            n++;
        end
        check_eq("restart_reached_train", phase, 2);
        cycle(1, 0, 1);
        check_eq("midrst_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            check_eq("midrst_no_done", done, 0);
        end

        // TRAIN base wraps and is truncated to the address width.
        set_counts(32'hFFFF_FFFF, 0, 1, 1, 0, 0, 1);
        run(0);
        check_eq("wrap_len", q_addr.size(), 1);
        if (q_addr.size() > 0) check_eq("wrap_addr", q_addr[0], 30'h3FFF_FFFF);

        // Randomized runs, back-to-back starts, random ready and stray starts.
        for (int r = 0; r < 30; r++) begin
            spp = $urandom_range(0, 3);
            t_i = $urandom_range(0, 7);
            t_r = $urandom_range(0, 9);
            t_t = $urandom_range(0, 7);
            s_i = (t_i + ((spp == 0) ? 1 : spp) - 1) / ((spp == 0) ? 1 : spp);
            s_r = (t_r + ((spp == 0) ? 1 : spp) - 1) / ((spp == 0) ? 1 : spp);
            s_t = (t_t + ((spp == 0) ? 1 : spp) - 1) / ((spp == 0) ? 1 : spp);
            if (t_r != 0 && $urandom_range(0, 3) == 0) s_r = s_r + 1;
            if (t_t != 0 && $urandom_range(0, 3) == 0) s_t = $urandom_range(0, 4);
            set_counts(s_i, t_i, s_r, t_r, s_t, t_t, spp);
            run(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
